// File: rtl/axi_pkg.sv
// Shared encodings and FSM state types for the AXI4 burst memory slave.
// Used by axi_addr_gen and axi_burst_mem_slave.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

endpackage

// File: rtl/axi_addr_gen.sv
// Combinational AXI next-beat address and burst legality check.
// One instance per channel.
module axi_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_len,
  input  logic [2:0]        i_size,
  input  logic [1:0]        i_burst,
  output logic [ADDR_W-1:0] o_next_addr,
  output logic              o_illegal
);

  localparam int LGB = $clog2(DATA_W/8);

  logic [ADDR_W-1:0] w_incr;
  logic [ADDR_W-1:0] w_bound;
  logic [ADDR_W-1:0] w_mask;
  logic [ADDR_W-1:0] w_sum;
  logic              w_wrap_len_ok;

  assign w_incr  = ADDR_W'(1) << i_size;
  assign w_bound = (ADDR_W'(i_len) + ADDR_W'(1)) << i_size;
  assign w_mask  = w_bound - ADDR_W'(1);
  assign w_sum   = i_addr + w_incr;

  assign w_wrap_len_ok =
    i_len inside {8'd1, 8'd3, 8'd7, 8'd15};

  always_comb begin
    o_next_addr = i_addr;
    case (i_burst)
      BURST_INCR: o_next_addr = w_sum;
      BURST_WRAP: o_next_addr =
        (i_addr & ~w_mask) | (w_sum & w_mask);
      default: ;
    endcase
  end

  assign o_illegal =
    (i_burst == BURST_RSVD) ||
    (i_size > 3'(LGB)) ||
    ((i_burst == BURST_WRAP) && !w_wrap_len_ok);

endmodule

// File: rtl/axi_burst_mem_slave.sv
// Parametrised AXI4 burst memory slave with strobes, WRAP and SLVERR.
// Define AXI_ID_EN to add AWID/ARID inputs and BID/RID outputs.
module axi_burst_mem_slave
  import axi_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 256,
  parameter int ID_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [7:0]          AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [7:0]          ARLEN,
  input  logic [2:0]          ARSIZE,
  input  logic [1:0]          ARBURST,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY
`ifdef AXI_ID_EN
  ,
  input  logic [ID_W-1:0]     AWID,
  input  logic [ID_W-1:0]     ARID,
  output logic [ID_W-1:0]     BID,
  output logic [ID_W-1:0]     RID
`endif
);

  localparam int NB  = DATA_W/8;
  localparam int LGB = $clog2(NB);
  localparam int LGD = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];

  w_state_t          r_wst, w_wst_nxt;
  logic [ADDR_W-1:0] r_waddr;
  logic [7:0]        r_wlen, r_wcnt;
  logic [2:0]        r_wsize;
  logic [1:0]        r_wburst;
  logic              r_werr;
  logic [ADDR_W-1:0] w_wnext;
  logic              w_will, w_woor, w_wlastb, w_we;
  logic [LGD-1:0]    w_widx;

  axi_addr_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wgen (
    .i_addr      (r_waddr),
    .i_len       (r_wlen),
    .i_size      (r_wsize),
    .i_burst     (r_wburst),
    .o_next_addr (w_wnext),
    .o_illegal   (w_will)
  );

  assign w_widx   = r_waddr[LGB +: LGD];
  assign w_woor   = |(r_waddr >> (LGB + LGD));
  assign w_wlastb = (r_wcnt == r_wlen);
  assign w_we     = (r_wst == W_DATA) && WVALID &&
                    !w_will && !w_woor;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_wst <= W_IDLE;
    else        r_wst <= w_wst_nxt;
  end

  always_comb begin
    w_wst_nxt = r_wst;
    AWREADY   = 1'b0;
    WREADY    = 1'b0;
    BVALID    = 1'b0;
    BRESP     = RESP_OKAY;
    case (r_wst)
      W_IDLE: begin
        AWREADY = 1'b1;
        if (AWVALID) w_wst_nxt = W_DATA;
      end
      W_DATA: begin
        WREADY = 1'b1;
        if (WVALID && w_wlastb) w_wst_nxt = W_RESP;
      end
      W_RESP: begin
        BVALID = 1'b1;
        BRESP  = (r_werr || w_will) ? RESP_SLVERR : RESP_OKAY;
        if (BREADY) w_wst_nxt = W_IDLE;
      end
      default: w_wst_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_waddr  <= '0;
      r_wlen   <= '0;
      r_wsize  <= '0;
      r_wburst <= '0;
      r_wcnt   <= '0;
      r_werr   <= 1'b0;
    end else if (r_wst == W_IDLE && AWVALID) begin
      r_waddr  <= AWADDR;
      r_wlen   <= AWLEN;
      r_wsize  <= AWSIZE;
      r_wburst <= AWBURST;
      r_wcnt   <= '0;
      r_werr   <= 1'b0;
    end else if (r_wst == W_DATA && WVALID) begin
      r_waddr <= w_wnext;
      r_wcnt  <= r_wcnt + 8'd1;
      r_werr  <= r_werr || (WLAST != w_wlastb) || w_woor;
    end
  end

  // Memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (w_we && WSTRB[b])
        r_mem[w_widx][b*8 +: 8] <= WDATA[b*8 +: 8];
    end
  end

  r_state_t          r_rst, w_rst_nxt;
  logic [ADDR_W-1:0] r_raddr;
  logic [7:0]        r_rlen, r_rcnt;
  logic [2:0]        r_rsize;
  logic [1:0]        r_rburst;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_rresp;
  logic              r_rlast;
  logic [ADDR_W-1:0] w_ra, w_rnext, w_rfetch;
  logic [7:0]        w_rl;
  logic [2:0]        w_rs;
  logic [1:0]        w_rb;
  logic              w_rill, w_roor, w_rload, w_ridle;
  logic [LGD-1:0]    w_ridx;

  // In idle the generator sees the AR request so the first beat can be fetched.
  assign w_ridle  = (r_rst == R_IDLE);
  assign w_ra     = w_ridle ? ARADDR  : r_raddr;
  assign w_rl     = w_ridle ? ARLEN   : r_rlen;
  assign w_rs     = w_ridle ? ARSIZE  : r_rsize;
  assign w_rb     = w_ridle ? ARBURST : r_rburst;
  assign w_rfetch = w_ridle ? ARADDR  : w_rnext;

  axi_addr_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rgen (
    .i_addr      (w_ra),
    .i_len       (w_rl),
    .i_size      (w_rs),
    .i_burst     (w_rb),
    .o_next_addr (w_rnext),
    .o_illegal   (w_rill)
  );

  assign w_ridx = w_rfetch[LGB +: LGD];
  assign w_roor = |(w_rfetch >> (LGB + LGD));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rst <= R_IDLE;
    else        r_rst <= w_rst_nxt;
  end

  always_comb begin
    w_rst_nxt = r_rst;
    ARREADY   = 1'b0;
    RVALID    = 1'b0;
    w_rload   = 1'b0;
    case (r_rst)
      R_IDLE: begin
        ARREADY = 1'b1;
        if (ARVALID) begin
          w_rst_nxt = R_DATA;
          w_rload   = 1'b1;
        end
      end
      R_DATA: begin
        RVALID = 1'b1;
        if (RREADY) begin
          if (r_rlast) w_rst_nxt = R_IDLE;
          else         w_rload   = 1'b1;
        end
      end
      default: w_rst_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_raddr  <= '0;
      r_rlen   <= '0;
      r_rsize  <= '0;
      r_rburst <= '0;
      r_rcnt   <= '0;
      r_rlast  <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else begin
      if (w_ridle && ARVALID) begin
        r_raddr  <= ARADDR;
        r_rlen   <= ARLEN;
        r_rsize  <= ARSIZE;
        r_rburst <= ARBURST;
        r_rcnt   <= '0;
        r_rlast  <= (ARLEN == 8'd0);
      end else if (!w_ridle && RREADY) begin
        if (r_rlast) begin
          r_rlast <= 1'b0;
        end else begin
          r_raddr <= w_rnext;
          r_rcnt  <= r_rcnt + 8'd1;
          r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
        end
      end
      if (w_rload) begin
        r_rdata <= (w_rill || w_roor) ? '0 : r_mem[w_ridx];
        r_rresp <= (w_rill || w_roor) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  assign RDATA = r_rdata;
  assign RRESP = r_rresp;
  assign RLAST = r_rlast;

`ifdef AXI_ID_EN
  logic [ID_W-1:0] r_bid, r_rid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bid <= '0;
      r_rid <= '0;
    end else begin
      if (r_wst == W_IDLE && AWVALID) r_bid <= AWID;
      if (w_ridle && ARVALID)         r_rid <= ARID;
    end
  end

  assign BID = r_bid;
  assign RID = r_rid;
`endif

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Directed, table-driven bench for axi_burst_mem_slave (32-bit, 256 words).
// Multi-cycle corners (stall, concurrent AW/AR, reset) are hand-written.
module tb_axi_burst_mem_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
`ifdef AXI_ID_EN
  logic [3:0]  AWID, ARID, BID, RID;
`endif

  always #5 clk = ~clk;

  axi_burst_mem_slave #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(256), .ID_W(4)
  ) dut (
    .clk(clk), .reset(reset),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY)
`ifdef AXI_ID_EN
    , .AWID(AWID), .ARID(ARID), .BID(BID), .RID(RID)
`endif
  );

  typedef struct packed {
    logic            wr;
    logic [31:0]     addr;
    logic [7:0]      len;
    logic [2:0]      sz;
    logic [1:0]      bt;
    logic [3:0]      sl;
    logic            wb;
    logic [7:0][31:0] d;
    logic [7:0][1:0]  rsp;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl [NV];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timeout", nm);
  endtask

  function automatic vec_t mk(input logic wr, input logic [31:0] a,
                              input logic [7:0] len, input logic [2:0] sz,
                              input logic [1:0] bt, input logic [31:0] base,
                              input logic [1:0] rsp);
    vec_t v;
    v.wr = wr; v.addr = a; v.len = len; v.sz = sz; v.bt = bt;
    v.sl = 4'hF; v.wb = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v.d[i]   = base + 32'(i);
      v.rsp[i] = rsp;
    end
    return v;
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bt,
                          input logic [7:0][31:0] d, input logic [3:0] sl,
                          input logic wb, output logic [1:0] resp);
    int t;
    resp = 2'b01;
    AWADDR = a; AWLEN = len; AWSIZE = sz; AWBURST = bt; AWVALID = 1'b1;
    t = 0;
    while (!AWREADY && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin tmo("aw_handshake"); AWVALID = 1'b0; return; end
    @(negedge clk);
    AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      WDATA  = d[i];
      WSTRB  = (i == int'(len)) ? sl : 4'hF;
      WLAST  = (i == int'(len)) && !wb;
      WVALID = 1'b1;
      t = 0;
      while (!WREADY && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) begin tmo("w_beat"); WVALID = 1'b0; return; end
      @(negedge clk);
    end
    WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
    t = 0;
    while (!BVALID && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin tmo("b_resp"); BREADY = 1'b0; return; end
    resp = BRESP;
    @(negedge clk);
    BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bt,
                         output logic [7:0][31:0] q,
                         output logic [7:0][1:0] rr,
                         output logic [7:0] rl);
    int t;
    q = '1; rr = '1; rl = '1;
    ARADDR = a; ARLEN = len; ARSIZE = sz; ARBURST = bt; ARVALID = 1'b1;
    t = 0;
    while (!ARREADY && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin tmo("ar_handshake"); ARVALID = 1'b0; return; end
    @(negedge clk);
    ARVALID = 1'b0;
    RREADY = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      t = 0;
      while (!RVALID && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) begin tmo("r_beat"); RREADY = 1'b0; return; end
      q[i] = RDATA; rr[i] = RRESP; rl[i] = RLAST;
      @(negedge clk);
    end
    RREADY = 1'b0;
  endtask

  task automatic w_beats_conc();
    int t;
    for (int i = 0; i < 4; i++) begin
      WDATA = 32'h700 + 32'(i); WSTRB = 4'hF;
      WLAST = (i == 3); WVALID = 1'b1;
      t = 0;
      while (!WREADY && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) begin tmo("conc_w_beat"); WVALID = 1'b0; return; end
      @(negedge clk);
    end
    WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
    t = 0;
    while (!BVALID && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin tmo("conc_b"); BREADY = 1'b0; return; end
    chk("conc_bresp", 32'(BRESP), 32'h0);
    @(negedge clk);
    BREADY = 1'b0;
  endtask

  task automatic r_beats_stall();
    int t;
    logic [31:0] held;
    RREADY = 1'b1;
    for (int b = 0; b < 4; b++) begin
      t = 0;
      while (!RVALID && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) begin tmo("stall_r_beat"); RREADY = 1'b0; return; end
      if (b == 1) begin
        RREADY = 1'b0;
        held = RDATA;
        @(negedge clk);
        chk("stall_hold", RDATA, held);
        chk("stall_rvalid", 32'(RVALID), 32'h1);
        RREADY = 1'b1;
      end
      chk($sformatf("stall_data%0d", b), RDATA, 32'h200 + 32'(b));
      chk($sformatf("stall_rlast%0d", b), 32'(RLAST), 32'(b == 3));
      @(negedge clk);
    end
    RREADY = 1'b0;
    chk("stall_rvalid_end", 32'(RVALID), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]       resp;
    logic [7:0][31:0] q;
    logic [7:0][1:0]  rr;
    logic [7:0]       rl;

    tbl[0]  = mk(1, 32'h20,  7, 2, 2'b01, 32'h200, 2'b00);
    tbl[1]  = mk(0, 32'h20,  7, 2, 2'b01, 32'h200, 2'b00);
    tbl[2]  = mk(1, 32'h48,  3, 2, 2'b10, 32'h300, 2'b00);
    tbl[3]  = mk(0, 32'h40,  3, 2, 2'b01, 32'h0,   2'b00);
    tbl[3].d[0] = 32'h302; tbl[3].d[1] = 32'h303;
    tbl[3].d[2] = 32'h300; tbl[3].d[3] = 32'h301;
    tbl[4]  = mk(1, 32'h0,   3, 2, 2'b00, 32'h100, 2'b00);
    tbl[4].sl = 4'b0001;
    tbl[5]  = mk(0, 32'h0,   0, 2, 2'b00, 32'h103, 2'b00);
    tbl[6]  = mk(1, 32'h400, 0, 2, 2'b01, 32'hDEAD0000, 2'b10);
    tbl[7]  = mk(0, 32'h400, 0, 2, 2'b01, 32'h0,   2'b10);
    tbl[8]  = mk(1, 32'h20,  0, 2, 2'b11, 32'hBAD, 2'b10);
    tbl[9]  = mk(0, 32'h20,  0, 2, 2'b01, 32'h200, 2'b00);
    tbl[10] = mk(0, 32'h20,  0, 2, 2'b11, 32'h0,   2'b10);
    tbl[11] = mk(1, 32'h24,  0, 3, 2'b01, 32'hBAD, 2'b10);
    tbl[12] = mk(0, 32'h24,  0, 2, 2'b01, 32'h201, 2'b00);
    tbl[13] = mk(1, 32'h28,  2, 2, 2'b10, 32'hBAD, 2'b10);
    tbl[14] = mk(0, 32'h28,  0, 2, 2'b01, 32'h202, 2'b00);
    tbl[15] = mk(1, 32'h30,  1, 2, 2'b01, 32'h500, 2'b10);
    tbl[15].wb = 1'b1;
    tbl[16] = mk(1, 32'h3F8, 3, 2, 2'b01, 32'h600, 2'b10);
    tbl[17] = mk(0, 32'h3F8, 3, 2, 2'b01, 32'h600, 2'b00);
    tbl[17].d[2] = 32'h0;    tbl[17].d[3] = 32'h0;
    tbl[17].rsp[2] = 2'b10;  tbl[17].rsp[3] = 2'b10;
    tbl[18] = mk(0, 32'h0,   0, 2, 2'b00, 32'h103, 2'b00);

    reset = 1'b0;
    AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
    RREADY = 1'b0;
`ifdef AXI_ID_EN
    AWID = '0; ARID = '0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_awready", 32'(AWREADY), 32'h1);
    chk("rst_arready", 32'(ARREADY), 32'h1);
    chk("rst_wready",  32'(WREADY),  32'h0);
    chk("rst_bvalid",  32'(BVALID),  32'h0);
    chk("rst_rvalid",  32'(RVALID),  32'h0);
    chk("rst_rlast",   32'(RLAST),   32'h0);
    chk("rst_resp",    {28'h0, BRESP, RRESP}, 32'h0);
    chk("rst_rdata",   RDATA, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    for (int k = 0; k < NV; k++) begin
      if (tbl[k].wr) begin
        do_write(tbl[k].addr, tbl[k].len, tbl[k].sz, tbl[k].bt,
                 tbl[k].d, tbl[k].sl, tbl[k].wb, resp);
        chk($sformatf("v%0d_bresp", k), 32'(resp), 32'(tbl[k].rsp[0]));
      end else begin
        do_read(tbl[k].addr, tbl[k].len, tbl[k].sz, tbl[k].bt, q, rr, rl);
        for (int i = 0; i <= int'(tbl[k].len); i++) begin
          chk($sformatf("v%0d_rdata%0d", k, i), q[i], tbl[k].d[i]);
          chk($sformatf("v%0d_rresp%0d", k, i), 32'(rr[i]),
              32'(tbl[k].rsp[i]));
          chk($sformatf("v%0d_rlast%0d", k, i), 32'(rl[i]),
              32'(i == int'(tbl[k].len)));
        end
      end
    end

    // Concurrent AW/AR in one cycle, with a read stall on beat 1.
    AWADDR = 32'h80; AWLEN = 8'd3; AWSIZE = 3'd2; AWBURST = 2'b01;
    ARADDR = 32'h20; ARLEN = 8'd3; ARSIZE = 3'd2; ARBURST = 2'b01;
    AWVALID = 1'b1; ARVALID = 1'b1;
    chk("conc_ready", {30'h0, AWREADY, ARREADY}, 32'h3);
    @(negedge clk);
    AWVALID = 1'b0; ARVALID = 1'b0;
    chk("conc_active", {30'h0, WREADY, RVALID}, 32'h3);
    fork
      w_beats_conc();
      r_beats_stall();
    join
    do_read(32'h80, 8'd3, 3'd2, 2'b01, q, rr, rl);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("conc_rb%0d", i), q[i], 32'h700 + 32'(i));
    end

    // Reset in the middle of a write data phase.
    AWADDR = 32'hA0; AWLEN = 8'd3; AWSIZE = 3'd2; AWBURST = 2'b01;
    AWVALID = 1'b1;
    @(negedge clk);
    AWVALID = 1'b0;
    WVALID = 1'b1; WSTRB = 4'hF; WLAST = 1'b0; WDATA = 32'h800;
    @(negedge clk);
    WDATA = 32'h801;
    @(negedge clk);
    chk("mid_wready", 32'(WREADY), 32'h1);
    reset = 1'b0;
    WVALID = 1'b0;
    @(posedge clk);
    #1;
    chk("rstmid_wready",  32'(WREADY),  32'h0);
    chk("rstmid_bvalid",  32'(BVALID),  32'h0);
    chk("rstmid_awready", 32'(AWREADY), 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    q = '0;
    q[0] = 32'h900; q[1] = 32'h901;
    do_write(32'h90, 8'd1, 3'd2, 2'b01, q, 4'hF, 1'b0, resp);
    chk("post_rst_bresp", 32'(resp), 32'h0);
    do_read(32'h90, 8'd1, 3'd2, 2'b01, q, rr, rl);
    chk("post_rst_rd0", q[0], 32'h900);
    chk("post_rst_rd1", q[1], 32'h901);
    do_read(32'hA0, 8'd1, 3'd2, 2'b01, q, rr, rl);
    chk("kept_rd0", q[0], 32'h800);
    chk("kept_rd1", q[1], 32'h801);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_burst_mem_slave.md
Name: axi_burst_mem_slave

Overview:
- Parametrised AXI4 memory slave and successor to the team's fixed-width 32-bit burst slave.
- Adds configurable data width, memory depth and AxSIZE, byte-lane write strobes, correct WRAP arithmetic, and SLVERR reporting for illegal or out-of-range accesses.
- Sits behind the interconnect as a scratch RAM and acts as the reference target for master-side benches.
- Write and read channels run independently and concurrently, with one outstanding burst per direction.

Parameters:
- DATA_W, 32, data bus width in bits; allowed values are 32, 64, 128.
- ADDR_W, 32, address width in bits.
- DEPTH, 256, memory size in DATA_W-bit words; must be a power of two.
- ID_W, 4, transaction ID width; used only with AXI_ID_EN.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- AWADDR  in  ADDR_W  write burst start byte address
- AWLEN  in  8  beats minus 1
- AWSIZE  in  3  bytes per beat = 2^AWSIZE
- AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- AWVALID  in  1  / AWREADY  out  1
- WDATA  in  DATA_W
- WSTRB  in  DATA_W/8  byte-lane enables
- WLAST  in  1
- WVALID  in  1  / WREADY  out  1
- BRESP  out  2  00 OKAY, 10 SLVERR
- BVALID  out  1  / BREADY  in  1
- ARADDR  in  ADDR_W
- ARLEN  in  8
- ARSIZE  in  3
- ARBURST  in  2
- ARVALID  in  1  / ARREADY  out  1
- RDATA  out  DATA_W
- RRESP  out  2
- RLAST  out  1
- RVALID  out  1  / RREADY  in  1

Behaviour:
- Reset values: AWREADY=1, ARREADY=1; WREADY, BVALID, RVALID, RLAST = 0; BRESP, RRESP, RDATA = 0. Memory contents are not reset.
- Reset asserted mid-burst aborts both FSMs to IDLE immediately. Memory writes already performed are kept.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: AWREADY=1. On AWVALID, latch addr/len/size/burst, clear the beat counter and error flag, go to W_DATA.
  - W_DATA: WREADY=1. Each WVALID cycle is one beat: write the enabled WSTRB lanes of word addr[log2(DATA_W/8)+:log2(DEPTH)], then advance the address and beat counter.
  - Exit W_DATA on the beat where counter==len. Set the error flag if WLAST!=(counter==len) on any beat.
  - W_RESP: BVALID=1, BRESP=SLVERR if the error flag is set, else OKAY. On BREADY go to W_IDLE.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: ARREADY=1. On ARVALID, latch the request, go to R_DATA.
  - R_DATA: RVALID=1. RDATA is registered, and the first beat is valid in the cycle after the AR handshake (1-cycle latency).
  - On RVALID&&RREADY: advance the address, load the next word into RDATA the next cycle, and count the beat.
  - RLAST=1 when counter==len. The handshake on the RLAST beat returns the FSM to R_IDLE.
  - If RREADY is low, RDATA, RRESP and RLAST hold stable.
- Address generation, with incr = 2^size:
  - FIXED: address constant.
  - INCR: addr + incr, with no 4 KB check.
  - WRAP: bound = (len+1)*incr; next = (addr & ~(bound-1)) | ((addr+incr) & (bound-1)).
- Error conditions make the burst SLVERR: burst==11; size > log2(DATA_W/8); WRAP with len not in {1,3,7,15}; any beat word index >= DEPTH.
  - Error bursts still complete every beat.
  - Writes in an error burst are suppressed for the whole burst, except that out-of-range beats suppress only themselves.
  - Reads in an error burst return RDATA=0 and RRESP=SLVERR on the affected beats. Illegal burst/size/len errors affect all beats.
- A write and a read beat to the same word in the same cycle: the read returns the pre-write value.
- AW and AR accepted in the same cycle are both serviced concurrently.

Optional Feature:
- Macro: AXI_ID_EN.
- Defined: adds AWID/ARID inputs and BID/RID outputs, each ID_W wide. IDs are latched at the address handshake and echoed on BID and on every R beat of the burst. BID and RID reset to 0.
- Undefined: none of these ports or registers exist.

Decomposition:
- Package axi_pkg holds:
  - burst encodings BURST_FIXED/INCR/WRAP;
  - response encodings RESP_OKAY/RESP_SLVERR;
  - FSM state typedefs for write and read.
- One sub-module, axi_addr_gen, is combinational next-address and legality logic. It takes addr, len, size and burst, and produces next_addr and illegal. It is instantiated once per channel.

Test Plan:
- INCR, AWADDR=0x20, AWLEN=7, size 2, data 0x200..0x207, then read back → all 8 beats match, RLAST only on beat 7, BRESP=RRESP=00.
- WRAP, AWADDR=0x48, AWLEN=3, size 2, data 0x300..0x303, then INCR read of 4 beats at 0x40 → read order 0x302,0x303,0x300,0x301.
- FIXED, AWADDR=0x0, AWLEN=3, data 0x100..0x103 with WSTRB=0001 on the last beat → word 0 = 0x00000103 upper bytes from 0x102, i.e. 0x00000103 low byte over 0x102.
- Write with AWADDR=DEPTH*DATA_W/8 (out of range), or AWBURST=11 → BRESP=10, memory unchanged. Read of the same address → RRESP=10, RDATA=0.
- RREADY toggled 1-0-1 during a 4-beat read → RDATA is stable while stalled, no beat is lost, and concurrent AW/AR issued in one cycle both complete.
- reset pulsed low in the middle of W_DATA → WREADY=0 and BVALID=0 next edge, AWREADY=1. A following burst completes OKAY.
